// File: rtl/stack_monitor.sv
// Stack overflow monitor: watches the CPU stack pointer, tracks the lowest value
// seen, latches the PC of the first limit violation, and exposes all of it on the I/O bus.
module stack_monitor #(
  parameter logic [31:0] HWM_INIT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [31:0] spx,
  input  logic [23:0] pcx,
  output logic        trip
);

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_LIM  = 2'd1,
    REG_HWM  = 2'd2,
    REG_TPC  = 2'd3
  } reg_sel_e;

  reg_sel_e    sel;
  logic [31:0] sp_r;
  logic [23:0] pc_r;
  logic        en;
  logic        trip_f;
  logic [31:0] lim;
  logic [31:0] hwm;
  logic [23:0] tpc;

  logic        wr_ctrl, wr_lim, wr_hwm;
  logic        violate, new_low;
  logic [31:0] rd_data;

  assign sel = reg_sel_e'(addr);

  // Comparisons use the registered SP and the pre-write en/lim/hwm, so a bus
  // write landing on the same edge never affects that edge's evaluation.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ctrl = 1'b0;
    wr_lim  = 1'b0;
    wr_hwm  = 1'b0;
    rd_data = '0;
    if (stb && we) begin
      wr_ctrl = (sel == REG_CTRL);
      wr_lim  = (sel == REG_LIM);
      wr_hwm  = (sel == REG_HWM);
    end
    unique case (sel)
      REG_CTRL: rd_data = {30'd0, trip_f, en};
      REG_LIM:  rd_data = lim;
      REG_HWM:  rd_data = hwm;
      REG_TPC:  rd_data = {8'd0, tpc};
    endcase
    violate = en && (sp_r < lim);
    new_low = en && (sp_r < hwm);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r     <= '0;
      pc_r     <= '0;
      en       <= 1'b0;
      trip_f   <= 1'b0;
      lim      <= '0;
      hwm      <= HWM_INIT;
      tpc      <= '0;
      ack      <= 1'b0;
      data_out <= '0;
    end else begin
      sp_r <= spx;
      pc_r <= pcx;

      if (wr_ctrl) en <= data_in[0];
      if (wr_lim)  lim <= data_in;

      // A violation outranks a software clear issued on the same edge.
      if (violate) begin
        trip_f <= 1'b1;
        if (!trip_f) tpc <= pc_r;
      end else if (wr_ctrl && data_in[1]) begin
        trip_f <= 1'b0;
      end

      if (wr_hwm)       hwm <= data_in;
      else if (new_low) hwm <= sp_r;

      ack      <= stb;
      data_out <= (stb && !we) ? rd_data : '0;
    end
  end

  assign trip = trip_f;

endmodule
